// File: rtl/sonar_pkg.sv
// Shared constants and helpers for the sonar message transmitter.
package sonar_pkg;

  // TX FSM state encodings (also exported on db_estado)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Fixed message characters and length
  localparam logic [6:0] CHAR_VIRGULA   = 7'h2C;
  localparam logic [6:0] CHAR_CERQUILHA = 7'h23;
  localparam int unsigned MSG_LEN       = 8;

  // Digit to ASCII; non-BCD digits fall through to 0x3A..0x3F on purpose
  function automatic logic [6:0] bcd_to_ascii(input logic [3:0] digito);
    return {3'b011, digito};
  endfunction

endpackage

// File: rtl/tx_serial_7E2.sv
// Asynchronous 7E2 serial transmitter: start, 7 data LSB first, even parity, 2 stops.
module tx_serial_7E2
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados,
  output logic       saida_serial,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam int unsigned M  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW = $clog2(2 * M);

  logic [2:0]    r_estado;
  logic [2:0]    w_prox;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [6:0]    r_dados;
  logic          w_fim_bit;
  logic          w_fim_stop;

  assign w_fim_bit  = (r_cnt == CW'(M - 1));
  assign w_fim_stop = (r_cnt == CW'(2 * M - 1));
  assign db_estado  = r_estado;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_estado <= ST_IDLE;
    else       r_estado <= w_prox;
  end

  // Next-state logic; partida is only honoured in IDLE
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      ST_IDLE:   if (partida) w_prox = ST_START;
      ST_START:  if (w_fim_bit) w_prox = ST_DATA;
      ST_DATA:   if (w_fim_bit && (r_bit == 3'd6)) w_prox = ST_PARITY;
      ST_PARITY: if (w_fim_bit) w_prox = ST_STOP;
      ST_STOP:   if (w_fim_stop) w_prox = ST_DONE;
      ST_DONE:   w_prox = ST_IDLE;
      default:   w_prox = ST_IDLE;
    endcase
  end

  // Baud counter, data bit index and latched character
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_dados <= 7'd0;
    end else begin
      if (r_estado == ST_IDLE && partida) begin
        r_dados <= dados;
        r_bit   <= 3'd0;
      end
      if (w_prox != r_estado) begin
        r_cnt <= '0;
      end else if (r_estado == ST_DATA && w_fim_bit) begin
        r_cnt <= '0;
        r_bit <= r_bit + 3'd1;
      end else if (r_estado != ST_IDLE && r_estado != ST_DONE) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Registered line and completion pulse, one cycle behind the FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      saida_serial <= 1'b1;
      pronto       <= 1'b0;
    end else begin
      case (r_estado)
        ST_START:  saida_serial <= 1'b0;
        ST_DATA:   saida_serial <= r_dados[r_bit];
        ST_PARITY: saida_serial <= ^r_dados;
        default:   saida_serial <= 1'b1;
      endcase
      pronto <= (r_estado == ST_DONE);
    end
  end

endmodule

// File: rtl/sonar_mensagem_tx.sv
// Sequences the "AAA,DDD#" message one character per partida over a 7E2 line.
module sonar_mensagem_tx
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        zera,
  input  logic        conta,
  input  logic        partida,
  input  logic [11:0] angulo,
  input  logic [11:0] distancia,
  output logic        saida_serial,
  output logic        pronto,
  output logic        fim,
  output logic [2:0]  db_indice,
  output logic [2:0]  db_estado
);

  logic [2:0] r_indice;
  logic [6:0] w_char;

  assign db_indice = r_indice;
  assign fim       = (r_indice == 3'(MSG_LEN - 1));

  // Character index: zera wins over conta, 3-bit wrap gives 7 -> 0
  always_ff @(posedge clock) begin
    if (reset || zera) r_indice <= 3'd0;
    else if (conta)    r_indice <= r_indice + 3'd1;
  end

  // Character multiplexer for the current index
  always_comb begin
    w_char = CHAR_CERQUILHA;
    case (r_indice)
      3'd0:    w_char = bcd_to_ascii(angulo[11:8]);
      3'd1:    w_char = bcd_to_ascii(angulo[7:4]);
      3'd2:    w_char = bcd_to_ascii(angulo[3:0]);
      3'd3:    w_char = CHAR_VIRGULA;
      3'd4:    w_char = bcd_to_ascii(distancia[11:8]);
      3'd5:    w_char = bcd_to_ascii(distancia[7:4]);
      3'd6:    w_char = bcd_to_ascii(distancia[3:0]);
      default: w_char = CHAR_CERQUILHA;
    endcase
  end

  tx_serial_7E2 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_tx (
    .clock       (clock),
    .reset       (reset),
    .partida     (partida),
    .dados       (w_char),
    .saida_serial(saida_serial),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

endmodule
